// File: rtl/fan_pkg.sv
// Shared constants, FSM encodings and frame byte helper for the fan status UART transmitter.
// FAN_TX_PARITY_EN adds the even-parity bit state to the byte serialiser.
package fan_pkg;

    localparam logic [7:0] FRM_HDR    = 8'h46;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam int         FRAME_LEN  = 7;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_LOAD = 2'd1,
        FS_SEND = 2'd2,
        FS_DONE = 2'd3
    } frame_state_t;

    typedef enum logic [2:0] {
        BS_IDLE   = 3'd0,
        BS_START  = 3'd1,
        BS_DATA   = 3'd2,
`ifdef FAN_TX_PARITY_EN
        BS_PARITY = 3'd4,
`endif
        BS_STOP   = 3'd3
    } byte_state_t;

    typedef struct packed {
        logic [1:0] speed;
        logic       auto_mode;
        logic [1:0] timer;
        logic       emcy;
    } status_t;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input status_t s);
        case (idx)
            3'd0:    frame_byte = FRM_HDR;
            3'd1:    frame_byte = ASCII_ZERO + {6'b0, s.speed};
            3'd2:    frame_byte = ASCII_ZERO + {7'b0, s.auto_mode};
            3'd3:    frame_byte = ASCII_ZERO + {6'b0, s.timer};
            3'd4:    frame_byte = ASCII_ZERO + {7'b0, s.emcy};
            3'd5:    frame_byte = CR;
            default: frame_byte = LF;
        endcase
    endfunction

endpackage

// File: rtl/fan_status_uart_tx_if.sv
// Status inputs, report request and UART line/handshake outputs of the fan status transmitter.
interface fan_status_uart_tx_if;

    logic [1:0] speed_lvl;
    logic       auto_mode;
    logic [1:0] timer_lvl;
    logic       emcy;
    logic       req;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        output speed_lvl, auto_mode, timer_lvl, emcy, req,
        input  tx, busy, frame_done
    );

    modport slave (
        input  speed_lvl, auto_mode, timer_lvl, emcy, req,
        output tx, busy, frame_done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: start, 8 data bits LSB first, optional even parity, stop.
// FAN_TX_PARITY_EN inserts the parity bit; a start during the last stop cycle chains bytes gaplessly.
module uart_tx_byte
    import fan_pkg::*;
#(
    parameter int BIT_CLKS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int             CNT_W     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CLKS - 1);

    byte_state_t      state, state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             load;
`ifdef FAN_TX_PARITY_EN
    logic             par;
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign done    = (state == BS_STOP) && bit_end;
    assign load    = start && ((state == BS_IDLE) || done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BS_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef FAN_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if ((state == BS_IDLE) || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if ((state == BS_DATA) && bit_end)
                bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                shreg <= data;
`ifdef FAN_TX_PARITY_EN
                par   <= ^data;
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BS_IDLE:   if (start) state_nxt = BS_START;
            BS_START:  if (bit_end) state_nxt = BS_DATA;
`ifdef FAN_TX_PARITY_EN
            BS_DATA:   if (bit_end && (bit_cnt == 3'd7)) state_nxt = BS_PARITY;
            BS_PARITY: if (bit_end) state_nxt = BS_STOP;
`else
            BS_DATA:   if (bit_end && (bit_cnt == 3'd7)) state_nxt = BS_STOP;
`endif
            BS_STOP:   if (bit_end) state_nxt = start ? BS_START : BS_IDLE;
            default:   state_nxt = BS_IDLE;
        endcase
    end

    // Line level is decoded from registered state so reset forces idle-high at once.
    always_comb begin
        tx = 1'b1;
        case (state)
            BS_START:  tx = 1'b0;
            BS_DATA:   tx = shreg[bit_cnt];
`ifdef FAN_TX_PARITY_EN
            BS_PARITY: tx = par;
`endif
            default:   tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/fan_status_uart_tx.sv
// Fan status transmitter: sends the 7-byte ASCII status frame on change or on request.
// FAN_TX_PARITY_EN (see uart_tx_byte) selects 11 bit-times per byte instead of 10.
//
// state   | meaning
// IDLE    | line idle, waiting for req, pending req or status change
// LOAD    | capture status snapshot, clear pend, start byte 0
// SEND    | bytes 0..6 shifting out back-to-back
// DONE    | one-cycle frame_done pulse
module fan_status_uart_tx
    import fan_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fan_status_uart_tx_if.slave   bus
);

    localparam int         BIT_CLKS  = CLK_HZ / BAUD;
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

    frame_state_t state, state_nxt;
    status_t      cur, snap;
    logic         pend;
    logic [2:0]   byte_idx;
    logic         trigger;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_done;
    logic         tx_line;

    assign cur     = {bus.speed_lvl, bus.auto_mode, bus.timer_lvl, bus.emcy};
    assign trigger = bus.req | pend | (cur != snap);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FS_IDLE;
            snap     <= '0;
            pend     <= 1'b0;
            byte_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == FS_LOAD) begin
                snap     <= cur;
                // A req landing in the LOAD cycle is already mid-frame, so it re-arms pend.
                pend     <= bus.req;
                byte_idx <= '0;
            end else begin
                if ((state != FS_IDLE) && bus.req)
                    pend <= 1'b1;
                if ((state == FS_SEND) && byte_done && (byte_idx != LAST_BYTE))
                    byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_start = 1'b0;
        byte_data  = frame_byte((state == FS_LOAD) ? 3'd0 : byte_idx + 3'd1, snap);
        case (state)
            FS_IDLE: if (trigger) state_nxt = FS_LOAD;
            FS_LOAD: begin
                byte_start = 1'b1;
                state_nxt  = FS_SEND;
            end
            FS_SEND: begin
                if (byte_done) begin
                    if (byte_idx == LAST_BYTE)
                        state_nxt = FS_DONE;
                    else
                        byte_start = 1'b1;
                end
            end
            FS_DONE: state_nxt = FS_IDLE;
            default: state_nxt = FS_IDLE;
        endcase
    end

    uart_tx_byte #(.BIT_CLKS(BIT_CLKS)) u_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (byte_start),
        .data    (byte_data),
        .tx      (tx_line),
        .done    (byte_done)
    );

    assign bus.tx         = tx_line;
    assign bus.busy       = (state != FS_IDLE);
    assign bus.frame_done = (state == FS_DONE);

endmodule

// File: tb/tb_fan_status_uart_tx.sv
// Directed bench for fan_status_uart_tx at CLK_HZ=1000, BAUD=100 (10 clocks per bit).
// Define FAN_TX_PARITY_EN for both bench and RTL to exercise the parity build.
`timescale 1ns/1ps
module tb_fan_status_uart_tx;

    localparam int CLK_HZ   = 1000;
    localparam int BAUD     = 100;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int CLK_PER  = 10;
`ifdef FAN_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CLKS = 7 * NB * BIT_CLKS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fan_status_uart_tx_if bus();

    fan_status_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #(CLK_PER/2) clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_b [7];
    int  rx_wait, rx_fd_t, rx_fd_n, rx_ferr, rx_busy_err;
    bit  rx_got;
    time rx_start_time, rx_fd_time;

    function automatic logic [55:0] rx_word();
        return {rx_b[0], rx_b[1], rx_b[2], rx_b[3], rx_b[4], rx_b[5], rx_b[6]};
    endfunction

    // Waits (bounded) for a start bit, then decodes one frame at mid-bit samples.
    // t=0 is the first negedge with tx low; returns at t=FRAME_CLKS+1.
    task automatic rx_frame();
        int k, bp;
        rx_got = 0; rx_wait = 0; rx_fd_t = -1; rx_fd_n = 0; rx_ferr = 0; rx_busy_err = 0;
        for (int i = 0; i < 7; i++) rx_b[i] = 8'h00;
        while (!rx_got && rx_wait < 2000) begin
            @(negedge clk);
            rx_wait++;
            if (bus.tx === 1'b0) rx_got = 1;
        end
        if (rx_got) begin
            rx_start_time = $time;
            for (int t = 0; t <= FRAME_CLKS + 1; t++) begin
                if (t > 0) @(negedge clk);
                if ((t < FRAME_CLKS) && (t % BIT_CLKS == BIT_CLKS / 2)) begin
                    k  = (t / BIT_CLKS) / NB;
                    bp = (t / BIT_CLKS) % NB;
                    if (bp >= 1 && bp <= 8) rx_b[k][bp-1] = bus.tx;
                    else if (bp == 0 && bus.tx !== 1'b0) rx_ferr++;
                    else if (bp == NB - 1 && bus.tx !== 1'b1) rx_ferr++;
`ifdef FAN_TX_PARITY_EN
                    else if (bp == 9 && bus.tx !== ^rx_b[k]) rx_ferr++;
`endif
                end
                if (t < FRAME_CLKS && bus.busy !== 1'b1) rx_busy_err++;
                if (t == FRAME_CLKS + 1 && bus.busy !== 1'b0) rx_busy_err++;
                if (bus.frame_done === 1'b1) begin
                    rx_fd_n++;
                    if (rx_fd_t < 0) begin
                        rx_fd_t = t;
                        rx_fd_time = $time;
                    end
                end
            end
        end
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 bus.req = 1'b1;
        @(posedge clk); #1 bus.req = 1'b0;
    endtask

    task automatic test_reset();
        int tx_low = 0;
        int busy_hi = 0;
        bus.speed_lvl = 2'd0; bus.auto_mode = 1'b0; bus.timer_lvl = 2'd0;
        bus.emcy = 1'b0; bus.req = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values tx=%b busy=%b frame_done=%b required 1 0 0",
                     bus.tx, bus.busy, bus.frame_done);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) tx_low++;
            if (bus.busy !== 1'b0) busy_hi++;
        end
        total++;
        if (tx_low != 0) begin bad++; $display("FAIL reset_idle_tx low_cycles=%0d required 0", tx_low); end
        total++;
        if (busy_hi != 0) begin bad++; $display("FAIL reset_idle_busy busy_cycles=%0d required 0", busy_hi); end
    endtask

    task automatic test_status_change();
        int lows = 0;
        @(posedge clk); #1 bus.speed_lvl = 2'd2;
        rx_frame();
        total++;
        if (!rx_got) begin bad++; $display("FAIL change_timeout no start bit within 2000 cycles"); end
        // Driven just after edge N-1: LOAD at negedge 2, start bit visible at negedge 3.
        total++;
        if (rx_wait != 3) begin bad++; $display("FAIL change_latency got=%0d required 3", rx_wait); end
        total++;
        if (rx_word() !== 56'h46_32_30_30_30_0D_0A) begin
            bad++; $display("FAIL change_bytes got=%h required 46323030300d0a", rx_word());
        end
        total++;
        if (rx_fd_t != FRAME_CLKS) begin bad++; $display("FAIL change_done_time got=%0d required %0d", rx_fd_t, FRAME_CLKS); end
        total++;
        if (rx_fd_n != 1) begin bad++; $display("FAIL change_done_width got=%0d required 1", rx_fd_n); end
        total++;
        if (rx_ferr != 0) begin bad++; $display("FAIL change_framing errors=%0d required 0", rx_ferr); end
        total++;
        if (rx_busy_err != 0) begin bad++; $display("FAIL change_busy errors=%0d required 0", rx_busy_err); end
        repeat (300) begin @(negedge clk); if (bus.tx === 1'b0) lows++; end
        total++;
        if (lows != 0) begin bad++; $display("FAIL change_no_repeat low_cycles=%0d required 0", lows); end
    endtask

    task automatic test_back_to_back();
        time fd1;
        logic [55:0] w1;
        int lows = 0;
        pulse_req();
        fork
            rx_frame();
            begin
                repeat (100) @(posedge clk);
                #1 bus.req = 1'b1;
                @(posedge clk); #1 bus.req = 1'b0;
                repeat (200) @(posedge clk);
                #1 bus.req = 1'b1;
                @(posedge clk); #1 bus.req = 1'b0;
            end
        join
        w1  = rx_word();
        fd1 = rx_fd_time;
        total++;
        if (!rx_got || w1 !== 56'h46_32_30_30_30_0D_0A) begin
            bad++; $display("FAIL req_frame1 got=%h required 46323030300d0a", w1);
        end
        rx_frame();
        total++;
        if (!rx_got || rx_word() !== 56'h46_32_30_30_30_0D_0A) begin
            bad++; $display("FAIL req_frame2 got=%h required 46323030300d0a", rx_word());
        end
        // frame_done, IDLE, LOAD, then start bit: three cycles apart.
        total++;
        if (rx_start_time - fd1 != 3 * CLK_PER) begin
            bad++; $display("FAIL req_gap got=%0d ns required %0d ns", rx_start_time - fd1, 3 * CLK_PER);
        end
        repeat (1000) begin @(negedge clk); if (bus.tx === 1'b0) lows++; end
        total++;
        if (lows != 0) begin bad++; $display("FAIL req_third_frame low_cycles=%0d required 0", lows); end
    endtask

    task automatic test_mid_frame_change();
        time fd1;
        logic [55:0] w1;
        int lows = 0;
        pulse_req();
        fork
            rx_frame();
            begin
                repeat (230) @(posedge clk);
                #1 bus.timer_lvl = 2'd3;
            end
        join
        w1  = rx_word();
        fd1 = rx_fd_time;
        total++;
        if (!rx_got || w1 !== 56'h46_32_30_30_30_0D_0A) begin
            bad++; $display("FAIL timer_frame1 got=%h required 46323030300d0a", w1);
        end
        rx_frame();
        total++;
        if (!rx_got || rx_word() !== 56'h46_32_30_33_30_0D_0A) begin
            bad++; $display("FAIL timer_frame2 got=%h required 46323033300d0a", rx_word());
        end
        total++;
        if (rx_start_time - fd1 != 3 * CLK_PER) begin
            bad++; $display("FAIL timer_gap got=%0d ns required %0d ns", rx_start_time - fd1, 3 * CLK_PER);
        end
        repeat (300) begin @(negedge clk); if (bus.tx === 1'b0) lows++; end
        total++;
        if (lows != 0) begin bad++; $display("FAIL timer_third_frame low_cycles=%0d required 0", lows); end
    endtask

    task automatic test_glitch_no_followup();
        int lows = 0;
        pulse_req();
        fork
            rx_frame();
            begin
                repeat (150) @(posedge clk);
                #1 bus.emcy = 1'b1;
                repeat (200) @(posedge clk);
                #1 bus.emcy = 1'b0;
            end
        join
        total++;
        if (!rx_got || rx_word() !== 56'h46_32_30_33_30_0D_0A) begin
            bad++; $display("FAIL emcy_frame got=%h required 46323033300d0a", rx_word());
        end
        repeat (1000) begin @(negedge clk); if (bus.tx === 1'b0) lows++; end
        total++;
        if (lows != 0) begin bad++; $display("FAIL emcy_followup low_cycles=%0d required 0", lows); end
    endtask

    task automatic test_reset_mid_frame();
        int waited = 0;
        bit seen = 0;
        int lows = 0;
        int busy_hi = 0;
        @(posedge clk); #1 bus.speed_lvl = 2'd0; bus.timer_lvl = 2'd0;
        rx_frame();
        total++;
        if (!rx_got || rx_word() !== 56'h46_30_30_30_30_0D_0A) begin
            bad++; $display("FAIL zero_frame got=%h required 46303030300d0a", rx_word());
        end
        pulse_req();
        while (!seen && waited < 100) begin
            @(negedge clk); waited++;
            if (bus.tx === 1'b0) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL abort_timeout no start bit within 100 cycles"); end
        // Byte 3, data bit 4 is bit-time 3*NB+5; land a few cycles into it.
        repeat ((3 * NB + 5) * BIT_CLKS + 3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy busy=%b required 1", bus.busy); end
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_immediate tx=%b busy=%b required tx=1 busy=0", bus.tx, bus.busy);
        end
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (bus.tx === 1'b0) lows++;
            if (bus.busy !== 1'b0) busy_hi++;
        end
        total++;
        if (lows != 0 || busy_hi != 0) begin
            bad++; $display("FAIL abort_no_resend low_cycles=%0d busy_cycles=%0d required 0 0", lows, busy_hi);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_status_change();
        test_back_to_back();
        test_mid_frame_change();
        test_glitch_no_followup();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
